// File: rtl/frame_buffer_scheduler.sv
// Frame-buffer scheduler. It arbitrates VGA reads, queued pixel writes and back-buffer clears
// onto a single-port SRAM, and it owns the front/back buffer swap.
module frame_buffer_scheduler #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned SCREEN_H   = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        frame_done,
  input  logic [15:0] background_data,
  input  logic        vga_req,
  input  logic [9:0]  vga_x,
  input  logic [9:0]  vga_y,
  output logic [15:0] vga_data,
  output logic        vga_valid,
  input  logic        program_write,
  input  logic [9:0]  program_x,
  input  logic [9:0]  program_y,
  input  logic [15:0] program_data,
  output logic        program_ready,
  output logic        current_frame,
  output logic        clear_busy,
  output logic        drop_err,
  output logic [19:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [15:0] mem_rdata
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StDraw, StWaitSwap, StClear} state_e;

  typedef struct packed {
    logic [8:0]  y;
    logic [9:0]  x;
    logic [15:0] data;
  } wr_t;

  state_e     state_q, state_d;
  logic       frame_q, frame_d;
  logic [9:0] clr_x_q, clr_x_d;
  logic [8:0] clr_y_q, clr_y_d;
  logic       vga_valid_q;
  logic       drop_q;

  wr_t        fifo_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic       empty, full, push;
  logic       gnt_vga, gnt_fifo, gnt_clr;
  wr_t        head;

  logic unused_msb;
  assign unused_msb = ^{vga_y[9], program_y[9]};

  // Extra pointer bit distinguishes full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = fifo_q[rd_ptr_q[AW-1:0]];

  assign program_ready = !full && (state_q == StDraw);
  assign push          = program_write && program_ready;

  // Grants are gated by reset so the memory bus is idle while reset is held.
  assign gnt_vga  = reset_n && vga_req;
  assign gnt_fifo = reset_n && !vga_req && !empty;
  assign gnt_clr  = reset_n && !vga_req && empty && (state_q == StClear);

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_vga) begin
      mem_read = 1'b1;
      mem_addr = {frame_q, vga_y[8:0], vga_x};
    end else if (gnt_fifo) begin
      mem_write = 1'b1;
      mem_addr  = {~frame_q, head.y, head.x};
      mem_wdata = head.data;
    end else if (gnt_clr) begin
      mem_write = 1'b1;
      mem_addr  = {~frame_q, clr_y_q, clr_x_q};
      mem_wdata = background_data;
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    clr_x_d = clr_x_q;
    clr_y_d = clr_y_q;
    unique case (state_q)
      StDraw: begin
        if (frame_done) state_d = StWaitSwap;
      end
      StWaitSwap: begin
        if (frame_start && empty) begin
          state_d = StClear;
          frame_d = ~frame_q;
          clr_x_d = '0;
          clr_y_d = '0;
        end
      end
      StClear: begin
        if (gnt_clr) begin
          if (clr_x_q == 10'(SCREEN_W - 1)) begin
            clr_x_d = '0;
            if (clr_y_q == 9'(SCREEN_H - 1)) begin
              clr_y_d = '0;
              state_d = StDraw;
            end else begin
              clr_y_d = clr_y_q + 9'd1;
            end
          end else begin
            clr_x_d = clr_x_q + 10'd1;
          end
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StClear;
      frame_q     <= 1'b0;
      clr_x_q     <= '0;
      clr_y_q     <= '0;
      vga_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      clr_x_q     <= clr_x_d;
      clr_y_q     <= clr_y_d;
      vga_valid_q <= gnt_vga;
      drop_q      <= drop_q | (program_write && !program_ready);
      if (push)     wr_ptr_q <= wr_ptr_q + 1'b1;
      if (gnt_fifo) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[AW-1:0]] <= '{y: program_y[8:0], x: program_x, data: program_data};
  end

  // Read data arrives the cycle after mem_read, alongside the registered valid.
  assign vga_valid     = vga_valid_q;
  assign vga_data      = vga_valid_q ? mem_rdata : '0;
  assign current_frame = frame_q;
  assign clear_busy    = (state_q == StClear);
  assign drop_err      = drop_q;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Randomized bench for frame_buffer_scheduler against a queue-based reference model of the
// arbitration, write FIFO, clear sweep and buffer swap, using a reduced screen size.
module tb_frame_buffer_scheduler;

  localparam int unsigned W     = 16;
  localparam int unsigned H     = 4;
  localparam int unsigned DEPTH = 8;

  localparam int MDraw  = 0;
  localparam int MWait  = 1;
  localparam int MClear = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start, frame_done;
  logic [15:0] background_data;
  logic        vga_req;
  logic [9:0]  vga_x, vga_y;
  logic [15:0] vga_data;
  logic        vga_valid;
  logic        program_write;
  logic [9:0]  program_x, program_y;
  logic [15:0] program_data;
  logic        program_ready, current_frame, clear_busy, drop_err;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_read, mem_write;
  logic [15:0] mem_rdata = '0;

  frame_buffer_scheduler #(
    .FIFO_DEPTH(DEPTH),
    .SCREEN_W  (W),
    .SCREEN_H  (H)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .frame_start    (frame_start),
    .frame_done     (frame_done),
    .background_data(background_data),
    .vga_req        (vga_req),
    .vga_x          (vga_x),
    .vga_y          (vga_y),
    .vga_data       (vga_data),
    .vga_valid      (vga_valid),
    .program_write  (program_write),
    .program_x      (program_x),
    .program_y      (program_y),
    .program_data   (program_data),
    .program_ready  (program_ready),
    .current_frame  (current_frame),
    .clear_busy     (clear_busy),
    .drop_err       (drop_err),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM stand-in: read data is a fixed function of the address, one cycle later.
  function automatic logic [15:0] rd_fn(input logic [19:0] a);
    return a[15:0] ^ {a[19:16], 12'ha5c};
  endfunction

  always @(posedge clk) mem_rdata <= mem_read ? rd_fn(mem_addr) : 16'h0;

  typedef struct packed {
    logic [8:0]  y;
    logic [9:0]  x;
    logic [15:0] d;
  } px_t;

  px_t         m_q[$];
  int          m_mode;
  int          m_clr_idx;
  int          m_clr_cnt;
  int          m_gnt;
  bit          m_frame, m_drop, m_vpend;
  logic [19:0] m_addr, m_vaddr;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mode    = MClear;
    m_frame   = 1'b0;
    m_clr_idx = 0;
    m_clr_cnt = 0;
    m_drop    = 1'b0;
    m_vpend   = 1'b0;
    m_vaddr   = '0;
  endtask

  task automatic check_all();
    logic [19:0] ea;
    logic [15:0] ew;
    bit          er, ewr, erdy;
    ea = '0; ew = '0; er = 0; ewr = 0; m_gnt = 0;
    if (reset_n) begin
      if (vga_req) begin
        m_gnt = 1; er = 1; ea = {m_frame, vga_y[8:0], vga_x};
      end else if (m_q.size() != 0) begin
        m_gnt = 2; ewr = 1; ea = {~m_frame, m_q[0].y, m_q[0].x}; ew = m_q[0].d;
      end else if (m_mode == MClear) begin
        m_gnt = 3; ewr = 1; ew = background_data;
        ea = {~m_frame, 9'(m_clr_idx / W), 10'(m_clr_idx % W)};
      end
    end
    m_addr = ea;
    erdy = reset_n && (m_mode == MDraw) && (m_q.size() < DEPTH);
    check("mem_read",  32'(mem_read),  32'(er));
    check("mem_write", 32'(mem_write), 32'(ewr));
    check("mem_addr",  32'(mem_addr),  32'(ea));
    check("mem_wdata", 32'(mem_wdata), 32'(ew));
    check("vga_valid", 32'(vga_valid), 32'(m_vpend));
    check("vga_data",  32'(vga_data),  m_vpend ? 32'(rd_fn(m_vaddr)) : 32'h0);
    check("program_ready", 32'(program_ready), 32'(erdy));
    check("current_frame", 32'(current_frame), 32'(m_frame));
    check("clear_busy", 32'(clear_busy), 32'(m_mode == MClear));
    check("drop_err",  32'(drop_err),  32'(m_drop));
    if (m_mode == MClear && mem_write === 1'b1 && mem_addr[19] === ~m_frame) m_clr_cnt++;
  endtask

  task automatic model_step();
    int  old_mode;
    int  sz0;
    bit  rdy;
    old_mode = m_mode;
    sz0      = m_q.size();
    rdy      = (m_mode == MDraw) && (sz0 < DEPTH);
    m_vpend  = (m_gnt == 1);
    m_vaddr  = m_addr;
    if (m_gnt == 2) void'(m_q.pop_front());
    if (program_write) begin
      if (rdy) m_q.push_back('{y: program_y[8:0], x: program_x, d: program_data});
      else     m_drop = 1'b1;
    end
    case (old_mode)
      MDraw: if (frame_done) m_mode = MWait;
      MWait: if (frame_start && sz0 == 0) begin
        m_mode = MClear; m_frame = ~m_frame; m_clr_idx = 0; m_clr_cnt = 0;
      end
      default: if (m_gnt == 3) begin
        m_clr_idx++;
        if (m_clr_idx == int'(W * H)) begin
          m_mode = MDraw;
          check("clear_writes", 32'(m_clr_cnt), 32'(W * H));
          m_clr_cnt = 0;
        end
      end
    endcase
  endtask

  // Entered and left at a falling edge with inputs already driven.
  task automatic cycle();
    #2 check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    frame_start = 0; frame_done = 0; vga_req = 0; program_write = 0;
    vga_x = '0; vga_y = '0; program_x = '0; program_y = '0; program_data = '0;
    background_data = 16'($urandom);
  endtask

  task automatic randomize_inputs(input int vr_pct, input int pw_pct, input int ev_pct);
    vga_req         = ($urandom_range(99) < vr_pct);
    vga_x           = 10'($urandom);
    vga_y           = 10'($urandom);
    program_write   = ($urandom_range(99) < pw_pct);
    program_x       = 10'($urandom);
    program_y       = 10'($urandom);
    program_data    = 16'($urandom);
    frame_done      = ($urandom_range(99) < ev_pct);
    frame_start     = ($urandom_range(99) < ev_pct);
    background_data = 16'($urandom);
  endtask

  task automatic do_reset();
    idle();
    #3 reset_n = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_clear(input int vr_pct, input int ev_pct);
    int n;
    n = 0;
    while (m_mode == MClear && n < 2000) begin
      randomize_inputs(vr_pct, 0, ev_pct);
      cycle();
      n++;
    end
    check("clear_finished", 32'(m_mode == MClear), 32'h0);
  endtask

  task automatic rand_cycles(input int n, input int vr_pct, input int pw_pct, input int ev_pct);
    for (int i = 0; i < n; i++) begin
      randomize_inputs(vr_pct, pw_pct, ev_pct);
      cycle();
    end
  endtask

  initial begin
    idle();
    @(negedge clk);
    do_reset();
    check("reset_busy", 32'(clear_busy), 32'h1);

    // Initial clear of frame 1 with VGA interference and ignored frame_done pulses.
    run_clear(25, 10);
    idle(); frame_start = 1; cycle();
    idle(); cycle();
    check("no_swap_after_clear", 32'(current_frame), 32'h0);

    // VGA priority over three queued writes.
    idle(); vga_req = 1; vga_x = 10'd5; vga_y = 10'd7;
    for (int i = 0; i < 4; i++) begin
      program_write = (i < 3); program_x = 10'($urandom); program_y = 10'($urandom);
      program_data = 16'($urandom);
      #1 check("vga_addr", 32'(mem_addr), 32'({1'b0, 9'd7, 10'd5}));
      cycle();
    end
    idle();
    #1 check("fifo_after_vga", 32'(mem_write), 32'h1);
    cycle();
    rand_cycles(6, 0, 0, 0);

    // Backpressure: nine pushes against a stalled FIFO.
    check("drop_clean", 32'(drop_err), 32'h0);
    idle(); vga_req = 1;
    for (int i = 0; i < 9; i++) begin
      program_write = 1; program_x = 10'(i); program_y = 10'(i + 1);
      program_data = 16'($urandom);
      cycle();
    end
    idle(); vga_req = 1;
    #1 check("bp_ready_low", 32'(program_ready), 32'h0);
    check("bp_drop", 32'(drop_err), 32'h1);
    cycle();
    idle(); rand_cycles(10, 0, 0, 0);

    rand_cycles(200, 30, 50, 0);

    // Swap with the FIFO drained.
    idle(); rand_cycles(8, 0, 0, 0);
    idle(); frame_done = 1; cycle();
    for (int i = 0; i < 10; i++) begin idle(); cycle(); end
    idle(); frame_start = 1; cycle();
    check("swap_frame", 32'(current_frame), 32'h1);
    check("swap_clear_target", 32'(mem_addr[19]), 32'h0);
    run_clear(20, 0);

    // frame_start with writes still queued is ignored.
    idle(); vga_req = 1;
    for (int i = 0; i < 3; i++) begin
      program_write = 1; program_data = 16'($urandom); frame_done = (i == 2); cycle();
    end
    idle(); vga_req = 1; frame_start = 1; cycle();
    check("gated_swap", 32'(current_frame), 32'h1);
    idle(); rand_cycles(5, 0, 0, 0);

    // Swap again, then reset partway through the clear.
    idle(); frame_start = 1; cycle();
    rand_cycles(30, 20, 0, 0);
    do_reset();
    #1 check("restart_addr", 32'(mem_addr), 32'h80000);
    cycle();
    run_clear(25, 5);

    // Fully random traffic, including simultaneous frame events.
    rand_cycles(1500, 30, 40, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
